// File: rtl/alu_cmd_frontend.sv
// Push-button front end for the ALU command FIFO: synchronizes and debounces the
// active-low button, then issues one gated write/read strobe (or reject) per press.
module alu_cmd_frontend #(
  parameter int unsigned DEBOUNCE_CYCLES = 2,
  parameter int unsigned COUNT_W         = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               button,
  input  logic               wren,
  input  logic [14:0]        dataIn,
  input  logic               full,
  input  logic               empty,
  output logic               fifo_wr,
  output logic               fifo_rd,
  output logic [14:0]        fifo_din,
  output logic               reject,
  output logic               busy,
  output logic [COUNT_W-1:0] accepted_count
);

  localparam int unsigned     CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_TGT = CNT_W'(DEBOUNCE_CYCLES);
  localparam bit              SINGLE  = (DEBOUNCE_CYCLES == 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ARM   = 2'd1;
  localparam logic [1:0] ISSUE = 2'd2;
  localparam logic [1:0] HOLD  = 2'd3;

  logic             btn_meta, btn_s;
  logic             wren_meta, wren_s;
  logic [1:0]       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
  logic             go_issue;
  logic             wr_ok, rd_ok;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      btn_meta  <= 1'b1;
      btn_s     <= 1'b1;
      wren_meta <= 1'b0;
      wren_s    <= 1'b0;
    end else begin
      btn_meta  <= button;
      btn_s     <= btn_meta;
      wren_meta <= wren;
      wren_s    <= wren_meta;
    end
  end

  assign cnt_inc = cnt + CNT_W'(1);

  // The strobe decision is taken on the edge that enters ISSUE, so the
  // strobes are registered yet high for exactly the ISSUE cycle.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    go_issue  = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (!btn_s) begin
          if (SINGLE) begin
            state_nxt = ISSUE;
            go_issue  = 1'b1;
          end else begin
            state_nxt = ARM;
            cnt_nxt   = CNT_W'(1);
          end
        end
      end
      ARM: begin
        if (btn_s) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt_inc == CNT_TGT) begin
          state_nxt = ISSUE;
          go_issue  = 1'b1;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      ISSUE: begin
        state_nxt = HOLD;
        cnt_nxt   = '0;
      end
      HOLD: begin
        if (!btn_s) begin
          cnt_nxt = '0;
        end else if (cnt_inc == CNT_TGT) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign wr_ok = go_issue &&  wren_s && !full;
  assign rd_ok = go_issue && !wren_s && !empty;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      cnt            <= '0;
      fifo_wr        <= 1'b0;
      fifo_rd        <= 1'b0;
      reject         <= 1'b0;
      fifo_din       <= '0;
      accepted_count <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      fifo_wr <= wr_ok;
      fifo_rd <= rd_ok;
      reject  <= go_issue && !wr_ok && !rd_ok;
      if (wr_ok)
        fifo_din <= dataIn;
      if (wr_ok || rd_ok)
        accepted_count <= accepted_count + COUNT_W'(1);
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_alu_cmd_frontend.sv
// Directed bench for alu_cmd_frontend: press timing, gating, reject, bounce, wrap and reset.
module tb_alu_cmd_frontend;

  logic        clock;
  logic        reset;
  logic        button;
  logic        wren;
  logic [14:0] dataIn;
  logic        full;
  logic        empty;
  logic        fifo_wr;
  logic        fifo_rd;
  logic [14:0] fifo_din;
  logic        reject;
  logic        busy;
  logic [7:0]  accepted_count;

  int n_cmp = 0;
  int n_bad = 0;

  alu_cmd_frontend #(
    .DEBOUNCE_CYCLES(2),
    .COUNT_W(8)
  ) dut (
    .clock(clock),
    .reset(reset),
    .button(button),
    .wren(wren),
    .dataIn(dataIn),
    .full(full),
    .empty(empty),
    .fifo_wr(fifo_wr),
    .fifo_rd(fifo_rd),
    .fifo_din(fifo_din),
    .reject(reject),
    .busy(busy),
    .accepted_count(accepted_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Index i is the sample taken just after edge k+i, where k is the first edge
  // that sees button low. Button is low on edges k..k+low-1 except k+bounce.
  task automatic run_press(input int low, input int total, input int bounce,
                           output int n_wr, output int n_rd, output int n_rej,
                           output int first_at, output int busy_seen);
    n_wr = 0; n_rd = 0; n_rej = 0; first_at = -1; busy_seen = 0;
    @(negedge clock);
    button = 1'b0;
    for (int i = 0; i < total; i++) begin
      @(negedge clock);
      if (fifo_wr) n_wr++;
      if (fifo_rd) n_rd++;
      if (reject)  n_rej++;
      if ((fifo_wr || fifo_rd || reject) && first_at < 0) first_at = i;
      if (busy) busy_seen = 1;
      button = ((i + 1 < low) && (i + 1 != bounce)) ? 1'b0 : 1'b1;
    end
  endtask

  task automatic settle(input int n);
    for (int i = 0; i < n; i++) @(negedge clock);
  endtask

  task automatic test_reset;
    reset = 1'b0; button = 1'b1; wren = 1'b0; dataIn = '0; full = 1'b0; empty = 1'b1;
    settle(3);
    n_cmp++; if (fifo_wr !== 1'b0) begin n_bad++; $display("FAIL reset_wr: got %b expected 0", fifo_wr); end
    n_cmp++; if (fifo_rd !== 1'b0) begin n_bad++; $display("FAIL reset_rd: got %b expected 0", fifo_rd); end
    n_cmp++; if (reject !== 1'b0) begin n_bad++; $display("FAIL reset_reject: got %b expected 0", reject); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_cmp++; if (fifo_din !== 15'h0) begin n_bad++; $display("FAIL reset_din: got %h expected 0000", fifo_din); end
    n_cmp++; if (accepted_count !== 8'd0) begin n_bad++; $display("FAIL reset_count: got %0d expected 0", accepted_count); end
    reset = 1'b1;
    settle(2);
  endtask

  task automatic test_write;
    int w, r, j, f, b;
    wren = 1'b1; dataIn = 15'h1A45; full = 1'b0; empty = 1'b1;
    settle(3);
    run_press(4, 14, -1, w, r, j, f, b);
    n_cmp++; if (w !== 1) begin n_bad++; $display("FAIL write_strobes: got %0d expected 1", w); end
    n_cmp++; if (f !== 3) begin n_bad++; $display("FAIL write_latency: got %0d expected 3", f); end
    n_cmp++; if (j !== 0 || r !== 0) begin n_bad++; $display("FAIL write_other: got rej=%0d rd=%0d expected 0 0", j, r); end
    n_cmp++; if (fifo_din !== 15'h1A45) begin n_bad++; $display("FAIL write_din: got %h expected 1a45", fifo_din); end
    n_cmp++; if (accepted_count !== 8'd1) begin n_bad++; $display("FAIL write_count: got %0d expected 1", accepted_count); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL write_idle: got busy=%b expected 0", busy); end
  endtask

  task automatic test_glitch;
    int w, r, j, f, b;
    run_press(1, 10, -1, w, r, j, f, b);
    n_cmp++; if (w + r + j !== 0) begin n_bad++; $display("FAIL glitch_pulses: got %0d expected 0", w + r + j); end
    n_cmp++; if (b !== 1) begin n_bad++; $display("FAIL glitch_busy_seen: got %0d expected 1", b); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL glitch_idle: got busy=%b expected 0", busy); end
    n_cmp++; if (accepted_count !== 8'd1) begin n_bad++; $display("FAIL glitch_count: got %0d expected 1", accepted_count); end
  endtask

  task automatic test_min_read;
    int w, r, j, f, b;
    wren = 1'b0; empty = 1'b0;
    settle(3);
    run_press(3, 12, -1, w, r, j, f, b);
    n_cmp++; if (r !== 1 || w !== 0) begin n_bad++; $display("FAIL minread_strobes: got rd=%0d wr=%0d expected 1 0", r, w); end
    n_cmp++; if (f !== 3) begin n_bad++; $display("FAIL minread_latency: got %0d expected 3", f); end
    n_cmp++; if (accepted_count !== 8'd2) begin n_bad++; $display("FAIL minread_count: got %0d expected 2", accepted_count); end
  endtask

  task automatic test_reject;
    int w, r, j, f, b;
    wren = 1'b1; full = 1'b1; empty = 1'b0; dataIn = 15'h0555;
    settle(3);
    run_press(4, 14, -1, w, r, j, f, b);
    n_cmp++; if (j !== 1 || w !== 0) begin n_bad++; $display("FAIL rejwr_pulses: got rej=%0d wr=%0d expected 1 0", j, w); end
    n_cmp++; if (fifo_din !== 15'h1A45) begin n_bad++; $display("FAIL rejwr_din: got %h expected 1a45", fifo_din); end
    wren = 1'b0; full = 1'b0; empty = 1'b1;
    settle(3);
    run_press(4, 14, -1, w, r, j, f, b);
    n_cmp++; if (j !== 1 || r !== 0) begin n_bad++; $display("FAIL rejrd_pulses: got rej=%0d rd=%0d expected 1 0", j, r); end
    n_cmp++; if (accepted_count !== 8'd2) begin n_bad++; $display("FAIL rej_count: got %0d expected 2", accepted_count); end
  endtask

  task automatic test_long_hold;
    int w, r, j, f, b;
    wren = 1'b0; empty = 1'b0; full = 1'b0;
    settle(3);
    run_press(50, 60, 20, w, r, j, f, b);
    n_cmp++; if (r !== 1 || w !== 0 || j !== 0) begin n_bad++; $display("FAIL hold_pulses: got rd=%0d wr=%0d rej=%0d expected 1 0 0", r, w, j); end
    n_cmp++; if (f !== 3) begin n_bad++; $display("FAIL hold_latency: got %0d expected 3", f); end
    n_cmp++; if (accepted_count !== 8'd3) begin n_bad++; $display("FAIL hold_count: got %0d expected 3", accepted_count); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL hold_idle: got busy=%b expected 0", busy); end
  endtask

  task automatic test_wrap;
    int w, r, j, f, b;
    int total_rd = 0;
    @(negedge clock); reset = 1'b0;
    @(negedge clock); reset = 1'b1;
    wren = 1'b0; empty = 1'b0; full = 1'b0;
    settle(3);
    for (int n = 0; n < 255; n++) begin
      run_press(3, 10, -1, w, r, j, f, b);
      total_rd += r;
    end
    n_cmp++; if (accepted_count !== 8'd255) begin n_bad++; $display("FAIL wrap_255: got %0d expected 255", accepted_count); end
    run_press(3, 10, -1, w, r, j, f, b);
    total_rd += r;
    n_cmp++; if (total_rd !== 256) begin n_bad++; $display("FAIL wrap_reads: got %0d expected 256", total_rd); end
    n_cmp++; if (accepted_count !== 8'd0) begin n_bad++; $display("FAIL wrap_zero: got %0d expected 0", accepted_count); end
  endtask

  task automatic test_reset_mid_hold;
    int first_at = -1;
    int n_wr = 0;
    wren = 1'b1; full = 1'b0; empty = 1'b1; dataIn = 15'h2222;
    settle(3);
    @(negedge clock); button = 1'b0;
    settle(8);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL midhold_busy: got %b expected 1", busy); end
    reset = 1'b0;
    #1;
    n_cmp++; if ({fifo_wr, fifo_rd, reject, busy} !== 4'b0) begin n_bad++; $display("FAIL midhold_flags: got %b expected 0000", {fifo_wr, fifo_rd, reject, busy}); end
    n_cmp++; if (fifo_din !== 15'h0 || accepted_count !== 8'd0) begin n_bad++; $display("FAIL midhold_regs: got din=%h cnt=%0d expected 0000 0", fifo_din, accepted_count); end
    settle(2);
    reset = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (fifo_wr) begin n_wr++; if (first_at < 0) first_at = i; end
    end
    n_cmp++; if (first_at !== 3 || n_wr !== 1) begin n_bad++; $display("FAIL postreset_strobe: got at=%0d n=%0d expected 3 1", first_at, n_wr); end
    n_cmp++; if (fifo_din !== 15'h2222) begin n_bad++; $display("FAIL postreset_din: got %h expected 2222", fifo_din); end
    button = 1'b1;
    settle(8);
    n_cmp++; if (busy !== 1'b0 || accepted_count !== 8'd1) begin n_bad++; $display("FAIL postreset_end: got busy=%b cnt=%0d expected 0 1", busy, accepted_count); end
  endtask

  initial begin
    test_reset;
    test_write;
    test_glitch;
    test_min_read;
    test_reject;
    test_long_hold;
    test_wrap;
    test_reset_mid_hold;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
